// File: rtl/reg_writeback_if.sv
// Bundle of the issue, ALU, LSU and register-file write-port signals around reg_writeback.
// The master drives results and issue info; the slave (reg_writeback) drives ready, write port and status.
interface reg_writeback_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // valid/ready: a transfer happens on a rising edge where both are 1; a source
  // holding valid must keep idx/data stable until ready is seen.
  logic          issue_valid;
  logic [4:0]    issue_idx;
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_idx;
  logic [31:0]   alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_idx;
  logic [31:0]   lsu_data;
  logic          w_en;
  logic [4:0]    w_idx;
  logic [31:0]   w_data;
  logic [31:0]   busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output issue_valid, issue_idx,
    output alu_valid, alu_idx, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_idx, lsu_data,
    input  lsu_ready,
    input  w_en, w_idx, w_data, busy, fifo_count
  );

  modport slave (
    input  issue_valid, issue_idx,
    input  alu_valid, alu_idx, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_idx, lsu_data,
    output lsu_ready,
    output w_en, w_idx, w_data, busy, fifo_count
  );
endinterface

// File: rtl/reg_writeback.sv
// Register-file write-port arbiter: ALU results win, LSU results queue in a FIFO
// with a starvation counter, and a per-register busy scoreboard tracks pending writes.
module reg_writeback #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic           clk,
  input logic           rst_n,
  reg_writeback_if.slave wb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_mem_idx  [FIFO_DEPTH];
  logic [31:0]   r_mem_data [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_wait_cnt;
  logic [31:0]   r_busy;
  logic          r_w_en;
  logic [4:0]    r_w_idx;
  logic [31:0]   r_w_data;

  logic          w_empty;
  logic          w_full;
  logic          w_force;
  logic          w_alu_wr;
  logic          w_pop;
  logic          w_push;
  logic          w_wr_en;
  logic [4:0]    w_wr_idx;
  logic [31:0]   w_wr_data;
  logic [31:0]   w_clr;
  logic [31:0]   w_set;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_force  = (r_wait_cnt == SW'(STARVE_LIMIT)) && !w_empty;

  // Ready signals come only from registered state so upstream never sees a comb loop.
  assign wb.alu_ready = !w_force;
  assign wb.lsu_ready = !w_full;

  assign w_alu_wr = !w_force && wb.alu_valid && (wb.alu_idx != 5'd0);
  assign w_pop    = !w_empty && !w_alu_wr;
  assign w_push   = wb.lsu_valid && !w_full && (wb.lsu_idx != 5'd0);

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = 5'd0;
    w_wr_data = 32'd0;
    if (w_alu_wr) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = wb.alu_idx;
      w_wr_data = wb.alu_data;
    end else if (w_pop) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_mem_idx[r_rd_ptr];
      w_wr_data = r_mem_data[r_rd_ptr];
    end
  end

  assign w_clr = w_wr_en ? (32'd1 << w_wr_idx) : 32'd0;
  assign w_set = (wb.issue_valid && (wb.issue_idx != 5'd0)) ? (32'd1 << wb.issue_idx) : 32'd0;

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_idx[r_wr_ptr]  <= wb.lsu_idx;
      r_mem_data[r_wr_ptr] <= wb.lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_wait_cnt <= '0;
      r_busy     <= 32'd0;
      r_w_en     <= 1'b0;
      r_w_idx    <= 5'd0;
      r_w_data   <= 32'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_empty || w_pop)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != SW'(STARVE_LIMIT))
        r_wait_cnt <= r_wait_cnt + SW'(1);
      // Set is applied after clear so a same-cycle reissue keeps the bit busy.
      r_busy   <= ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
      r_w_en   <= w_wr_en;
      r_w_idx  <= w_wr_idx;
      r_w_data <= w_wr_data;
    end
  end

  assign wb.w_en       = r_w_en;
  assign wb.w_idx      = r_w_idx;
  assign wb.w_data     = r_w_data;
  assign wb.busy       = r_busy;
  assign wb.fifo_count = r_count;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset, ALU path, starvation, x0, set/clear
// collision, mid-traffic reset and a randomized drain check with expected queues.
module tb_reg_writeback;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  reg_writeback_if #(.FIFO_DEPTH(4)) wb ();

  reg_writeback #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb.issue_valid = 1'b0; wb.issue_idx = 5'd0;
    wb.alu_valid   = 1'b0; wb.alu_idx   = 5'd0; wb.alu_data = 32'd0;
    wb.lsu_valid   = 1'b0; wb.lsu_idx   = 5'd0; wb.lsu_data = 32'd0;
  endtask

  logic [63:0] alu_q[$];
  logic [63:0] exp_q[$];

  task automatic check_write();
    logic [63:0] e;
    if (wb.w_en) begin
      if (wb.w_idx >= 5'd16) begin
        if (alu_q.size() == 0) chk("rnd_alu_unexpected", {27'd0, wb.w_idx, wb.w_data}, 64'd0);
        else begin
          e = alu_q.pop_front();
          chk("rnd_alu_write", {27'd0, wb.w_idx, wb.w_data}, e);
        end
      end else begin
        if (exp_q.size() == 0) chk("rnd_lsu_unexpected", {27'd0, wb.w_idx, wb.w_data}, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("rnd_lsu_write", {27'd0, wb.w_idx, wb.w_data}, e);
        end
      end
    end
  endtask

  initial begin
    int lsu_sent;
    int cyc;
    int r;
    logic alu_took;
    logic lsu_took;
    logic [31:0] lsu_ctr;

    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();

    // Reset state
    step();
    chk("rst_w_en", wb.w_en, 1'b0);
    chk("rst_w_idx", wb.w_idx, 5'd0);
    chk("rst_w_data", wb.w_data, 32'd0);
    chk("rst_busy", wb.busy, 32'd0);
    chk("rst_count", wb.fifo_count, 3'd0);
    chk("rst_lsu_ready", wb.lsu_ready, 1'b1);
    chk("rst_alu_ready", wb.alu_ready, 1'b1);
    rst_n = 1'b1;

    // ALU write to x5
    step();
    wb.issue_valid = 1'b1; wb.issue_idx = 5'd5;
    step();
    chk("alu_busy_set", wb.busy, 32'h0000_0020);
    wb.issue_valid = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_idx = 5'd5; wb.alu_data = 32'hDEAD_BEEF;
    chk("alu_ready_idle", wb.alu_ready, 1'b1);
    step();
    chk("alu_w_en", wb.w_en, 1'b1);
    chk("alu_w_idx", wb.w_idx, 5'd5);
    chk("alu_w_data", wb.w_data, 32'hDEAD_BEEF);
    chk("alu_busy_clr", wb.busy, 32'd0);
    wb.alu_valid = 1'b0;
    step();
    chk("alu_w_en_drop", wb.w_en, 1'b0);

    // Priority and starvation: ALU x7 held while x1..x4 queue
    wb.alu_valid = 1'b1; wb.alu_idx = 5'd7; wb.alu_data = 32'h0000_0077;
    for (int i = 1; i <= 4; i++) begin
      wb.lsu_valid = 1'b1; wb.lsu_idx = 5'(i); wb.lsu_data = 32'h100 + 32'(i);
      chk("pri_lsu_ready", wb.lsu_ready, 1'b1);
      step();
      chk("pri_alu_wins", {wb.w_en, wb.w_idx}, {1'b1, 5'd7});
    end
    wb.lsu_valid = 1'b0;
    chk("pri_full_count", wb.fifo_count, 3'd4);
    chk("pri_full_ready", wb.lsu_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pri_wait_alu_ready", wb.alu_ready, 1'b1);
    end
    step();
    chk("pri_force_alu_ready", wb.alu_ready, 1'b0);
    chk("pri_force_count", wb.fifo_count, 3'd4);
    wb.alu_valid = 1'b0;
    step();
    chk("pri_force_write", {wb.w_en, wb.w_idx, wb.w_data}, {1'b1, 5'd1, 32'h101});
    chk("pri_alu_ready_back", wb.alu_ready, 1'b1);
    chk("pri_lsu_ready_back", wb.lsu_ready, 1'b1);
    chk("pri_count3", wb.fifo_count, 3'd3);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("pri_order", {wb.w_en, wb.w_idx, wb.w_data}, {1'b1, 5'(i), 32'h100 + 32'(i)});
    end
    chk("pri_empty", wb.fifo_count, 3'd0);
    step();
    chk("pri_idle", wb.w_en, 1'b0);

    // x0 handling on every input
    wb.alu_valid = 1'b1; wb.alu_idx = 5'd0; wb.alu_data = 32'h1234_5678;
    wb.lsu_valid = 1'b1; wb.lsu_idx = 5'd0; wb.lsu_data = 32'h8765_4321;
    wb.issue_valid = 1'b1; wb.issue_idx = 5'd0;
    chk("x0_alu_ready", wb.alu_ready, 1'b1);
    chk("x0_lsu_ready", wb.lsu_ready, 1'b1);
    step();
    idle_inputs();
    chk("x0_no_write", wb.w_en, 1'b0);
    chk("x0_no_enq", wb.fifo_count, 3'd0);
    chk("x0_busy", wb.busy, 32'd0);
    step();
    chk("x0_still_idle", {wb.w_en, wb.fifo_count}, 4'd0);

    // Set/clear collision on x9
    wb.issue_valid = 1'b1; wb.issue_idx = 5'd9;
    step();
    wb.issue_valid = 1'b0;
    wb.lsu_valid = 1'b1; wb.lsu_idx = 5'd9; wb.lsu_data = 32'h909;
    chk("col_busy_set", wb.busy, 32'h0000_0200);
    step();
    wb.lsu_valid = 1'b0;
    wb.issue_valid = 1'b1; wb.issue_idx = 5'd9;
    chk("col_no_bypass", wb.w_en, 1'b0);
    chk("col_count1", wb.fifo_count, 3'd1);
    step();
    wb.issue_valid = 1'b0;
    chk("col_write", {wb.w_en, wb.w_idx, wb.w_data}, {1'b1, 5'd9, 32'h909});
    chk("col_busy_kept", wb.busy, 32'h0000_0200);
    wb.alu_valid = 1'b1; wb.alu_idx = 5'd9; wb.alu_data = 32'h9999;
    step();
    wb.alu_valid = 1'b0;
    chk("col_busy_cleared", wb.busy, 32'd0);

    // Reset mid-traffic
    wb.alu_valid = 1'b1; wb.alu_idx = 5'd7; wb.alu_data = 32'h77;
    for (int i = 1; i <= 3; i++) begin
      wb.issue_valid = 1'b1; wb.issue_idx = 5'(i);
      wb.lsu_valid = 1'b1; wb.lsu_idx = 5'(i); wb.lsu_data = 32'h200 + 32'(i);
      step();
    end
    idle_inputs();
    chk("mid_count3", wb.fifo_count, 3'd3);
    chk("mid_busy", wb.busy, 32'h0000_000E);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", wb.busy, 32'd0);
    chk("mid_rst_count", wb.fifo_count, 3'd0);
    chk("mid_rst_w_en", wb.w_en, 1'b0);
    chk("mid_rst_lsu_ready", wb.lsu_ready, 1'b1);
    step();
    rst_n = 1'b1;

    // Random traffic: ALU uses x16..x31, LSU uses x0..x15
    lsu_sent = 0;
    cyc = 0;
    alu_took = 1'b0;
    lsu_took = 1'b0;
    lsu_ctr = 32'd0;
    while (lsu_sent < 100 && cyc < 4000) begin
      step();
      cyc++;
      check_write();
      if (wb.fifo_count > 3'd4) chk("rnd_count_max", wb.fifo_count, 3'd4);
      if (!wb.alu_valid || alu_took) begin
        r = $urandom_range(0, 16);
        wb.alu_valid = ($urandom_range(0, 3) != 0);
        wb.alu_idx   = (r == 0) ? 5'd0 : 5'(15 + r);
        wb.alu_data  = $urandom;
      end
      if (!wb.lsu_valid || lsu_took) begin
        wb.lsu_valid = ($urandom_range(0, 1) != 0);
        wb.lsu_idx   = 5'($urandom_range(0, 15));
        wb.lsu_data  = 32'h1000_0000 + lsu_ctr;
        lsu_ctr++;
      end
      alu_took = wb.alu_valid && wb.alu_ready;
      lsu_took = wb.lsu_valid && wb.lsu_ready;
      if (alu_took && wb.alu_idx != 5'd0) alu_q.push_back({27'd0, wb.alu_idx, wb.alu_data});
      if (lsu_took && wb.lsu_idx != 5'd0) exp_q.push_back({27'd0, wb.lsu_idx, wb.lsu_data});
      if (lsu_took) lsu_sent++;
    end
    chk("rnd_transfers", lsu_sent, 100);
    step();
    idle_inputs();
    check_write();
    for (int i = 0; i < 20; i++) begin
      step();
      check_write();
    end
    chk("rnd_alu_drained", alu_q.size(), 0);
    chk("rnd_lsu_drained", exp_q.size(), 0);
    chk("rnd_final_count", wb.fifo_count, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side front end for the CPU's 32×32 register file: merges results from the single-cycle ALU and the variable-latency load/store unit (LSU) onto the file's single write port. It owns the pending-write scoreboard (one busy bit per architectural register) that the issue stage uses for RAW hazard stalls. LSU results are buffered in a small FIFO; the ALU has priority, with a starvation limit that back-pressures the ALU so the FIFO always drains.

## Interface
- FIFO_DEPTH, 4, LSU result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles a non-empty FIFO head may wait before the ALU is stalled (≥1)

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction issued with a register destination this cycle
- issue_idx  in  5  destination register of the issued instruction
- alu_valid  in  1  ALU result present; consumed only when alu_ready=1
- alu_ready  out  1  ALU result accepted this cycle
- alu_idx  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  LSU result present
- lsu_ready  out  1  FIFO can accept (= not full)
- lsu_idx  in  5  LSU destination register
- lsu_data  in  32  LSU result
- w_en  out  1  register file write enable (registered)
- w_idx  out  5  register file write index (registered)
- w_data  out  32  register file write data (registered)
- busy  out  32  per-register pending-write bitmap; bit 0 always 0
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- LSU handshake: transfer on lsu_valid & lsu_ready. lsu_idx≠0 → enqueue {idx,data}; lsu_idx=0 → accepted and dropped (no enqueue).
- Write-port select, per cycle, in priority order:
  - force = (wait_cnt == STARVE_LIMIT) & FIFO non-empty: pop FIFO head; alu_ready=0.
  - else alu_valid & alu_idx≠0: write ALU result; alu_ready=1.
  - else FIFO non-empty: pop FIFO head; alu_ready=1.
  - else no write; alu_ready=1.
- ALU result with alu_idx=0 and alu_ready=1 is consumed with no write; the FIFO may pop that cycle.
- alu_ready depends only on registered state (wait_cnt, FIFO occupancy), never on alu_valid.
- wait_cnt: 0 when FIFO empty or on any pop; else +1 per cycle, saturating at STARVE_LIMIT.
- Scoreboard, evaluated at each edge:
  - clear busy[i] when a write to i is selected this cycle;
  - set busy[i] on issue_valid & issue_idx=i≠0;
  - same index set and clear in the same cycle → set wins (busy stays 1).
- FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH; same-cycle enqueue and dequeue allowed when non-empty (count unchanged). No empty-FIFO bypass: an LSU result is written no earlier than the cycle after acceptance.
- Write order to the same register is not reordered: the FIFO is strictly in order; ALU/LSU ordering for the same register is the issue stage's responsibility, enforced via busy.

## Timing
- Reset (rst_n low, asynchronous): w_en=0, w_idx=0, w_data=0, busy=0, FIFO empty, fifo_count=0, wait_cnt=0; thus lsu_ready=1, alu_ready=1. Entries in flight are discarded.
- ALU result → w_en/w_idx/w_data valid 1 cycle after the accept edge.
- LSU result → earliest w_en 2 cycles after the accept edge (enqueue, pop, register).
- busy[i] clears at the same edge that registers w_en for i, so issue sees it clear one cycle before the file is written. The issue stage pairs this with a register-file read bypass.
- Full FIFO: lsu_ready=0 the cycle after the count reaches FIFO_DEPTH; it returns to 1 the cycle after a pop.
- Worst-case LSU head wait: STARVE_LIMIT+1 cycles under continuous alu_valid.

## Test plan
- Reset mid-traffic: 3 LSU entries queued and busy=0x0000_000E, assert rst_n=0 → busy=0, fifo_count=0, w_en=0 immediately; lsu_ready=1.
- ALU write: issue x5, then alu_valid idx=5 data=0xDEADBEEF → next cycle w_en=1, w_idx=5, w_data=0xDEADBEEF, busy[5]=0.
- Priority and FIFO: 4 LSU results (x1..x4) back-to-back with alu_valid held high on x7 → lsu_ready drops after the 4th; FIFO stalls until wait_cnt=8; then alu_ready=0 for one cycle and x1 is written; FIFO order x1..x4 is preserved.
- x0 handling: alu_idx=0, lsu_idx=0, issue_idx=0 → no w_en, no enqueue, busy[0]=0, both handshakes complete.
- Set/clear collision: busy[9]=1, FIFO head for x9 pops while issue_idx=9 in the same cycle → write occurs and busy[9] remains 1.
- Full/empty wrap: 100 random LSU transfers with random lsu_valid/alu_valid → every accepted nonzero-index result is written exactly once, in order per LSU. fifo_count never exceeds 4; pointer wrap is exercised.
